axi4_lite_main_memory: RTL and testbench
========================================

// Module: axi4_lite_main_memory
// PURPOSE
//  AXI4-Lite slave memory model sitting directly downstream of cache_top; serves line refills (AR/R) and dirty writebacks (AW/W/B).
//  Independent read and write channel FSMs with programmable fixed latency emulate slow main memory.
//  Word-organised array; used as the main-memory stage in cache system benches and integration.
// PARAMETERS
//  ADDRESS        32           address width, byte address
//  DATA           32           data width, one word per beat
//  DEPTH          1024         words in array; index = addr[2 +: $clog2(DEPTH)]
//  READ_LATENCY   4            cycles from AR handshake to r_valid; legal range >=1
//  WRITE_LATENCY  4            cycles from AW+W capture to b_valid; legal range >=1
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        reset, asynchronous, active-high
//  ar_address  in   ADDRESS  read address from cache
//  ar_valid    in   1        read address valid
//  ar_ready    out  1        read address accepted
//  r_data      out  DATA     read data
//  r_valid     out  1        read data valid
//  r_ready     in   1        cache ready for read data
//  aw_address  in   ADDRESS  write address
//  aw_valid    in   1        write address valid
//  aw_ready    out  1        write address accepted
//  w_data      in   DATA     write data
//  w_valid     in   1        write data valid
//  w_ready     out  1        write data accepted
//  b_valid     out  1        write response valid
//  b_ready     in   1        cache ready for response
//  b_response  out  1        0 = OKAY, 1 = error (out-of-range address)
// BEHAVIOUR
//  Reset (async, any cycle incl. mid-transaction): both FSMs -> IDLE, counters 0, captured flags cleared,
//   r_valid=0, b_valid=0, r_data=0, b_response=0, array cleared to 0; in-flight transactions dropped, no write committed.
//  Out of range: addr[ADDRESS-1:2] >= DEPTH. Low two address bits ignored.
//  Read FSM R_IDLE -> R_WAIT -> R_RESP:
//   R_IDLE: ar_ready=1. ar_valid&&ar_ready at edge N: latch address, cnt<=READ_LATENCY-1, -> R_WAIT.
//   R_WAIT: ar_ready=0; cnt!=0 -> decrement; cnt==0 -> r_data<=array[idx] (32'hDEADBEEF if out of range), -> R_RESP.
//   r_valid rises after edge N+READ_LATENCY. R_RESP: r_valid=1, r_data stable until r_valid&&r_ready -> R_IDLE.
//   Earliest next AR handshake is the edge after the R handshake (ar_ready low in R_RESP).
//  Write FSM W_IDLE -> W_WAIT -> W_RESP:
//   W_IDLE: aw_ready=!aw_got, w_ready=!w_got; AW and W captured independently in any order or same edge.
//   When both captured (flags or same-edge handshakes): cnt<=WRITE_LATENCY-1, -> W_WAIT; aw_ready=w_ready=0 outside W_IDLE.
//   W_WAIT: cnt==0 -> commit array[idx]<=w_data (skipped if out of range), b_response<=out_of_range, -> W_RESP.
//   W_RESP: b_valid=1 until b_valid&&b_ready -> W_IDLE, flags cleared.
//  Simultaneous events: read capture and write commit on same edge to same index -> read returns OLD word.
//   Read and write channels never stall each other. Counters are $clog2(max latency)+1 bits, no wrap.
// TESTING
//  Read, READ_LATENCY=4, array[5]=32'hA5A5_0001: ar_address=0x14 at edge N -> r_valid after edge N+4, r_data=32'hA5A5_0001.
//  Write W before AW: W(0xCAFE_F00D) edge 2, AW(0x20) edge 5 -> b_valid after edge 5+WRITE_LATENCY, b_response=0; read 0x20 -> 0xCAFE_F00D.
//  Backpressure: hold r_ready=0 10 cycles -> r_valid,r_data stable, ar_ready=0; r_ready=1 -> R_IDLE next edge.
//  Out of range: read 4*DEPTH -> 32'hDEADBEEF; write 4*DEPTH -> b_response=1, array unchanged.
//  Same-edge collision: write commit and read capture to index 3 (old 0x1, new 0x2) -> r_data=0x1; later read -> 0x2.
//  Reset in R_WAIT and W_WAIT -> r_valid=b_valid=0 immediately, no write committed, ar_ready=aw_ready=w_ready=1 after release.

Source files
------------

// File: rtl/axi4_lite_main_memory_if.sv
// AXI4-Lite bus between a cache (master) and the main-memory model (slave).
// It carries the AR/R read channels and the AW/W/B write channels.
interface axi4_lite_main_memory_if #(
  parameter int ADDRESS = 32,
  parameter int DATA    = 32
);
  logic [ADDRESS-1:0] ar_address;
  logic               ar_valid;
  logic               ar_ready;
  logic [DATA-1:0]    r_data;
  logic               r_valid;
  logic               r_ready;
  logic [ADDRESS-1:0] aw_address;
  logic               aw_valid;
  logic               aw_ready;
  logic [DATA-1:0]    w_data;
  logic               w_valid;
  logic               w_ready;
  logic               b_valid;
  logic               b_ready;
  logic               b_response;

  modport master (
    output ar_address, ar_valid, r_ready,
    output aw_address, aw_valid, w_data, w_valid, b_ready,
    input  ar_ready, r_data, r_valid,
    input  aw_ready, w_ready, b_valid, b_response
  );

  modport slave (
    input  ar_address, ar_valid, r_ready,
    input  aw_address, aw_valid, w_data, w_valid, b_ready,
    output ar_ready, r_data, r_valid,
    output aw_ready, w_ready, b_valid, b_response
  );
endinterface

// File: rtl/axi4_lite_main_memory.sv
// Slow main-memory model: word array behind an AXI4-Lite slave.
// Independent read and write FSMs each add a fixed, programmable latency.
module axi4_lite_main_memory #(
  parameter int ADDRESS       = 32,
  parameter int DATA          = 32,
  parameter int DEPTH         = 1024,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  axi4_lite_main_memory_if.slave        bus
);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [ADDRESS-1:0] DEPTH_W  = ADDRESS'(DEPTH);
  localparam logic [DATA-1:0]    BAD_WORD = DATA'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [DATA-1:0] mem [DEPTH];

  // ---------------- read channel ----------------
  r_state_t           r_state_reg, r_state_next;
  logic [CW-1:0]      r_cnt_reg;
  logic [ADDRESS-1:0] r_addr_reg;
  logic [DATA-1:0]    r_data_reg;
  logic [IDX_W-1:0]   r_idx;
  logic               r_oor;

  assign r_idx = r_addr_reg[2 +: IDX_W];
  assign r_oor = (r_addr_reg >> 2) >= DEPTH_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
    end else begin
      r_state_reg <= r_state_next;
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    unique case (r_state_reg)
      R_IDLE:  if (bus.ar_valid)      r_state_next = R_WAIT;
      R_WAIT:  if (r_cnt_reg == '0)   r_state_next = R_RESP;
      R_RESP:  if (bus.r_ready)       r_state_next = R_IDLE;
      default:                        r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    bus.ar_ready = (r_state_reg == R_IDLE);
    bus.r_valid  = (r_state_reg == R_RESP);
    bus.r_data   = r_data_reg;
  end

  // The array is sampled at the end of the wait, so a write committing on that
  // same edge is not yet visible and the read returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_reg  <= '0;
      r_addr_reg <= '0;
      r_data_reg <= '0;
    end else begin
      unique case (r_state_reg)
        R_IDLE: begin
          if (bus.ar_valid) begin
            r_addr_reg <= bus.ar_address;
            r_cnt_reg  <= CW'(READ_LATENCY - 1);
          end
        end
        R_WAIT: begin
          if (r_cnt_reg != '0) begin
            r_cnt_reg <= r_cnt_reg - CW'(1);
          end else begin
            r_data_reg <= r_oor ? BAD_WORD : mem[r_idx];
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- write channel ----------------
  w_state_t           w_state_reg, w_state_next;
  logic [CW-1:0]      w_cnt_reg;
  logic [ADDRESS-1:0] aw_addr_reg;
  logic [DATA-1:0]    w_data_reg;
  logic               aw_got_reg;
  logic               w_got_reg;
  logic               b_resp_reg;
  logic               aw_hs;
  logic               w_hs;
  logic               both_captured;
  logic               w_oor;
  logic               w_commit;
  logic [IDX_W-1:0]   w_idx;

  assign aw_hs         = (w_state_reg == W_IDLE) && !aw_got_reg && bus.aw_valid;
  assign w_hs          = (w_state_reg == W_IDLE) && !w_got_reg  && bus.w_valid;
  assign both_captured = (aw_got_reg || aw_hs) && (w_got_reg || w_hs);
  assign w_idx         = aw_addr_reg[2 +: IDX_W];
  assign w_oor         = (aw_addr_reg >> 2) >= DEPTH_W;
  assign w_commit      = (w_state_reg == W_WAIT) && (w_cnt_reg == '0) && !w_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
    end else begin
      w_state_reg <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    unique case (w_state_reg)
      W_IDLE:  if (both_captured)     w_state_next = W_WAIT;
      W_WAIT:  if (w_cnt_reg == '0)   w_state_next = W_RESP;
      W_RESP:  if (bus.b_ready)       w_state_next = W_IDLE;
      default:                        w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    bus.aw_ready   = (w_state_reg == W_IDLE) && !aw_got_reg;
    bus.w_ready    = (w_state_reg == W_IDLE) && !w_got_reg;
    bus.b_valid    = (w_state_reg == W_RESP);
    bus.b_response = b_resp_reg;
  end

  // AW and W may arrive in either order; each flag holds until the response completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_cnt_reg   <= '0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      aw_got_reg  <= 1'b0;
      w_got_reg   <= 1'b0;
      b_resp_reg  <= 1'b0;
    end else begin
      unique case (w_state_reg)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_reg <= bus.aw_address;
            aw_got_reg  <= 1'b1;
          end
          if (w_hs) begin
            w_data_reg <= bus.w_data;
            w_got_reg  <= 1'b1;
          end
          if (both_captured) begin
            w_cnt_reg <= CW'(WRITE_LATENCY - 1);
          end
        end
        W_WAIT: begin
          if (w_cnt_reg != '0) begin
            w_cnt_reg <= w_cnt_reg - CW'(1);
          end else begin
            b_resp_reg <= w_oor;
          end
        end
        W_RESP: begin
          if (bus.b_ready) begin
            aw_got_reg <= 1'b0;
            w_got_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- storage ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (w_commit) begin
      mem[w_idx] <= w_data_reg;
    end
  end

endmodule

// File: tb/tb_axi4_lite_main_memory.sv
// Bench for axi4_lite_main_memory: directed vector table, corner sequences
// and randomized traffic checked against a word-array reference model.
module tb_axi4_lite_main_memory;
  localparam int ADDRESS = 32;
  localparam int DATA    = 32;
  localparam int DEPTH   = 1024;
  localparam int RL      = 4;
  localparam int WL      = 4;

  logic clk = 1'b0;
  logic rst;

  axi4_lite_main_memory_if #(.ADDRESS(ADDRESS), .DATA(DATA)) bus ();

  axi4_lite_main_memory #(
    .ADDRESS(ADDRESS), .DATA(DATA), .DEPTH(DEPTH),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
    int          aw_dly;
    int          w_dly;
    logic [31:0] expect_val;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] word;
    word = addr >> 2;
    if (word >= DEPTH) return 32'hDEAD_BEEF;
    return model_mem[word];
  endfunction

  function automatic logic model_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] word;
    word = addr >> 2;
    if (word >= DEPTH) return 1'b1;
    model_mem[word] = data;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
    int n;
    bus.ar_address = addr;
    bus.ar_valid   = 1'b1;
    bus.r_ready    = 1'b1;
    n = 0;
    while (!bus.ar_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    bus.ar_valid = 1'b0;
    lat = 0;
    while (!bus.r_valid && lat < 100) begin
      tick();
      lat++;
    end
    data = bus.r_data;
    tick();
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly,
                           output logic resp, output int lat);
    int cyc;
    bit aw_done;
    bit w_done;
    bus.b_ready = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 200) begin
      bus.aw_address = addr;
      bus.w_data     = data;
      bus.aw_valid   = !aw_done && (cyc >= aw_dly);
      bus.w_valid    = !w_done && (cyc >= w_dly);
      if (bus.aw_valid && bus.aw_ready) aw_done = 1'b1;
      if (bus.w_valid && bus.w_ready) w_done = 1'b1;
      tick();
      cyc++;
    end
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    check("w_capture", {31'b0, aw_done && w_done}, 32'd1);
    lat = 0;
    while (!bus.b_valid && lat < 100) begin
      tick();
      lat++;
    end
    resp = bus.b_response;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    logic        resp;
    int          lat;
    int          n;

    rst            = 1'b1;
    bus.ar_address = '0;
    bus.ar_valid   = 1'b0;
    bus.r_ready    = 1'b1;
    bus.aw_address = '0;
    bus.aw_valid   = 1'b0;
    bus.w_data     = '0;
    bus.w_valid    = 1'b0;
    bus.b_ready    = 1'b1;
    model_clear();

    // reset state
    #7;
    check("rst_r_valid", {31'b0, bus.r_valid}, 32'd0);
    check("rst_b_valid", {31'b0, bus.b_valid}, 32'd0);
    check("rst_r_data", bus.r_data, 32'd0);
    check("rst_b_response", {31'b0, bus.b_response}, 32'd0);
    #6;
    rst = 1'b0;
    tick();
    check("idle_ar_ready", {31'b0, bus.ar_ready}, 32'd1);
    check("idle_aw_ready", {31'b0, bus.aw_ready}, 32'd1);
    check("idle_w_ready", {31'b0, bus.w_ready}, 32'd1);
    $display("txn reset_state done");

    // directed vectors: expect_val is read data or write response
    vecs[0]  = '{1'b1, 32'h0000_0014, 32'hA5A5_0001, 0, 0, 32'd0};
    vecs[1]  = '{1'b0, 32'h0000_0014, 32'h0,         0, 0, 32'hA5A5_0001};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 3, 0, 32'd0};
    vecs[3]  = '{1'b0, 32'h0000_0020, 32'h0,         0, 0, 32'hCAFE_F00D};
    vecs[4]  = '{1'b0, 32'h0000_1000, 32'h0,         0, 0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 0, 0, 32'd1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         0, 0, 32'd0};
    vecs[7]  = '{1'b1, 32'h0000_0017, 32'h0000_0055, 0, 2, 32'd0};
    vecs[8]  = '{1'b0, 32'h0000_0015, 32'h0,         0, 0, 32'h0000_0055};
    vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         0, 0, 32'd0};
    vecs[10] = '{1'b1, 32'h0000_0FFC, 32'hFEED_FACE, 1, 1, 32'd0};
    vecs[11] = '{1'b0, 32'h0000_0FFF, 32'h0,         0, 0, 32'hFEED_FACE};

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_write) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].aw_dly, vecs[i].w_dly, resp, lat);
        void'(model_write(vecs[i].addr, vecs[i].data));
        check($sformatf("vec%0d_bresp", i), {31'b0, resp}, vecs[i].expect_val);
        check($sformatf("vec%0d_wlat", i), lat, WL);
        $display("txn vec%0d write addr=%h data=%h resp=%0d lat=%0d", i, vecs[i].addr, vecs[i].data, resp, lat);
      end else begin
        axi_read(vecs[i].addr, rd, lat);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].expect_val);
        check($sformatf("vec%0d_rlat", i), lat, RL);
        $display("txn vec%0d read addr=%h data=%h lat=%0d", i, vecs[i].addr, rd, lat);
      end
    end

    // backpressure on R
    bus.r_ready    = 1'b0;
    bus.ar_address = 32'h0000_0014;
    bus.ar_valid   = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
    n = 0;
    while (!bus.r_valid && n < 50) begin
      tick();
      n++;
    end
    check("bp_lat", n, RL);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_r_valid", {31'b0, bus.r_valid}, 32'd1);
      check("bp_r_data", bus.r_data, model_read(32'h0000_0014));
      check("bp_ar_ready", {31'b0, bus.ar_ready}, 32'd0);
    end
    bus.r_ready = 1'b1;
    tick();
    check("bp_release_r_valid", {31'b0, bus.r_valid}, 32'd0);
    check("bp_release_ar_ready", {31'b0, bus.ar_ready}, 32'd1);
    $display("txn backpressure done");

    // same-edge collision on word 3
    axi_write(32'h0000_000C, 32'h1, 0, 0, resp, lat);
    void'(model_write(32'h0000_000C, 32'h1));
    bus.ar_address = 32'h0000_000C;
    bus.aw_address = 32'h0000_000C;
    bus.w_data     = 32'h2;
    bus.ar_valid   = 1'b1;
    bus.aw_valid   = 1'b1;
    bus.w_valid    = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    n = 0;
    while (!(bus.r_valid && bus.b_valid) && n < 50) begin
      tick();
      n++;
    end
    check("collide_lat", n, RL);
    check("collide_r_data", bus.r_data, 32'h1);
    tick();
    void'(model_write(32'h0000_000C, 32'h2));
    axi_read(32'h0000_000C, rd, lat);
    check("collide_after", rd, model_read(32'h0000_000C));
    $display("txn collision read_old=%h read_new=%h", 32'h1, rd);

    // reset while both FSMs wait
    bus.ar_address = 32'h0000_0080;
    bus.aw_address = 32'h0000_0080;
    bus.w_data     = 32'h0000_0077;
    bus.ar_valid   = 1'b1;
    bus.aw_valid   = 1'b1;
    bus.w_valid    = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rstwait_r_valid", {31'b0, bus.r_valid}, 32'd0);
    check("rstwait_b_valid", {31'b0, bus.b_valid}, 32'd0);
    model_clear();
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    check("rstwait_ar_ready", {31'b0, bus.ar_ready}, 32'd1);
    check("rstwait_aw_ready", {31'b0, bus.aw_ready}, 32'd1);
    check("rstwait_w_ready", {31'b0, bus.w_ready}, 32'd1);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.b_valid || bus.r_valid) n++;
      tick();
    end
    check("rstwait_no_resp", n, 0);
    axi_read(32'h0000_0080, rd, lat);
    check("rstwait_no_commit", rd, model_read(32'h0000_0080));
    axi_read(32'h0000_0014, rd, lat);
    check("rstwait_cleared", rd, model_read(32'h0000_0014));
    $display("txn reset_in_wait done");

    // reset while both responses are held
    axi_write(32'h0000_0040, 32'h0BAD_F00D, 0, 0, resp, lat);
    void'(model_write(32'h0000_0040, 32'h0BAD_F00D));
    bus.r_ready    = 1'b0;
    bus.b_ready    = 1'b0;
    bus.ar_address = 32'h0000_0040;
    bus.aw_address = 32'h0000_1100;
    bus.w_data     = 32'h1;
    bus.ar_valid   = 1'b1;
    bus.aw_valid   = 1'b1;
    bus.w_valid    = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    n = 0;
    while (!(bus.r_valid && bus.b_valid) && n < 50) begin
      tick();
      n++;
    end
    check("rstresp_r_data", bus.r_data, model_read(32'h0000_0040));
    check("rstresp_b_response", {31'b0, bus.b_response}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstresp_r_valid", {31'b0, bus.r_valid}, 32'd0);
    check("rstresp_b_valid", {31'b0, bus.b_valid}, 32'd0);
    check("rstresp_r_data0", bus.r_data, 32'd0);
    check("rstresp_b_resp0", {31'b0, bus.b_response}, 32'd0);
    model_clear();
    bus.r_ready = 1'b1;
    bus.b_ready = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    $display("txn reset_in_resp done");

    // randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
      else a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp, lat);
        check($sformatf("rnd%0d_bresp", i), {31'b0, resp}, {31'b0, model_write(a, d)});
        check($sformatf("rnd%0d_wlat", i), lat, WL);
        $display("txn rnd%0d write addr=%h data=%h resp=%0d", i, a, d, resp);
      end else begin
        axi_read(a, rd, lat);
        check($sformatf("rnd%0d_rdata", i), rd, model_read(a));
        check($sformatf("rnd%0d_rlat", i), lat, RL);
        $display("txn rnd%0d read addr=%h data=%h", i, a, rd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
